// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, pixel layout and widths for the VGA scanout
package vga_pkg;

  // 640x480 @ 60 Hz timing, in pixels / lines
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Frame-buffer word: {R[11:8], G[7:4], B[3:0]}
  localparam int PIX_W   = 12;
  localparam int CH_W    = 4;
  localparam int R_LSB   = 8;
  localparam int G_LSB   = 4;
  localparam int B_LSB   = 0;
  localparam int VRAM_AW = 15;

  // Counter width able to hold values 0..n-1 (at least one bit)
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel-clock divider, raster counters, sync and blanking strobes
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = 4
) (
  input  logic clk,
  input  logic rst,
  output logic pe,
  output logic active,
  output logic hs_raw,
  output logic vs_raw,
  output logic vblank_raw,
  output logic line_end,
  output logic frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra code so the exclusive sync end always fits, even with a zero back porch
  localparam int HW = cnt_w(H_TOTAL + 1);
  localparam int VW = cnt_w(V_TOTAL + 1);
  localparam int DW = cnt_w(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;

  // Pixel-clock divider: pe marks the last clk of every pixel period
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (pe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pe        = (div_cnt == DIV_LAST);
  assign line_end  = pe && (hcnt == H_LAST);
  assign frame_end = line_end && (vcnt == V_LAST);

  // Raster position: hcnt sweeps the line, vcnt steps once per line wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (pe) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  assign vblank_raw = (vcnt >= V_ACT_C);
  assign active     = (hcnt < H_ACT_C) && !vblank_raw;
  assign hs_raw     = (hcnt >= HS_START) && (hcnt < HS_END);
  assign vs_raw     = (vcnt >= VS_START) && (vcnt < VS_END);

endmodule

// File: rtl/vga_fb_scanout.sv
// rtl/vga_fb_scanout.sv - raster-order frame-buffer reader driving VGA RGB and sync
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = 4,
  parameter int RD_LAT   = 1,
  parameter int SCALE    = 4,
  parameter int FB_W     = H_ACTIVE / SCALE,
  parameter logic [VRAM_AW-1:0] FB_BASE = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [VRAM_AW-1:0] vram_addr,
  input  logic [PIX_W-1:0]   vram_data,
  output logic [CH_W-1:0]    vga_r,
  output logic [CH_W-1:0]    vga_g,
  output logic [CH_W-1:0]    vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vblank,
  output logic               frame_start
);

  // The address is held for a whole pixel period and sampled on its last clk,
  // so any read latency up to CLK_DIV-1 is absorbed without extra pipelining.
  generate
    if (CLK_DIV < 2 || RD_LAT < 0 || RD_LAT > CLK_DIV - 1 ||
        SCALE < 1 || SCALE > 8 || FB_W * SCALE != H_ACTIVE) begin : g_bad_cfg
      $error("vga_fb_scanout: illegal parameter combination");
    end
  endgenerate

  localparam logic [2:0]         SUB_LAST = 3'(SCALE - 1);
  localparam logic [VRAM_AW-1:0] FB_W_A   = VRAM_AW'(FB_W);

  logic pe;
  logic active;
  logic hs_raw;
  logic vs_raw;
  logic vblank_raw;
  logic line_end;
  logic frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pe         (pe),
    .active     (active),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .vblank_raw (vblank_raw),
    .line_end   (line_end),
    .frame_end  (frame_end)
  );

  logic [2:0]         x_sub;
  logic [2:0]         y_sub;
  logic [VRAM_AW-1:0] fb_x;
  logic [VRAM_AW-1:0] row_base;

  // Frame-buffer walk: next column every SCALE active pixels, next row every
  // SCALE active lines; row_base is accumulated so no multiplier is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      x_sub    <= '0;
      y_sub    <= '0;
      fb_x     <= '0;
      row_base <= '0;
    end else if (pe) begin
      if (frame_end) begin
        x_sub    <= '0;
        fb_x     <= '0;
        y_sub    <= '0;
        row_base <= '0;
      end else if (line_end) begin
        x_sub <= '0;
        fb_x  <= '0;
        if (!vblank_raw) begin
          if (y_sub == SUB_LAST) begin
            y_sub    <= '0;
            row_base <= row_base + FB_W_A;
          end else begin
            y_sub <= y_sub + 1'b1;
          end
        end
      end else if (active) begin
        if (x_sub == SUB_LAST) begin
          x_sub <= '0;
          fb_x  <= fb_x + 1'b1;
        end else begin
          x_sub <= x_sub + 1'b1;
        end
      end
    end
  end

  // Wraps modulo 2^15 by width, so a base near the top of memory is legal
  assign vram_addr = FB_BASE + row_base + fb_x;

  // Output stage: retire the current pixel on pe, one pixel period behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_r  <= '0;
      vga_g  <= '0;
      vga_b  <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
      vblank <= 1'b0;
    end else if (pe) begin
      vga_r  <= active ? vram_data[R_LSB +: CH_W] : '0;
      vga_g  <= active ? vram_data[G_LSB +: CH_W] : '0;
      vga_b  <= active ? vram_data[B_LSB +: CH_W] : '0;
      vga_hs <= !hs_raw;
      vga_vs <= !vs_raw;
      vblank <= vblank_raw;
    end
  end

  // Frame marker: single clk following the edge where the raster wraps to (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_end;
    end
  end

endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Read-only display engine on the far end of the data memory's screen read port.
- The CPU writes 12-bit pixels (RGB 4:4:4) into the shared frame buffer through the store path. This block generates VGA timing and walks the frame buffer in raster order through the second read port.
- It drives 4-bit R/G/B plus HS/VS to the board connector, and exports vblank/frame_start so software can synchronise updates.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=2)
- RD_LAT, 1, frame-buffer read latency in clk cycles; must be <= CLK_DIV-1
- SCALE, 4, screen pixels per frame-buffer pixel in each axis (1..8)
- FB_W, 160, frame-buffer width = H_ACTIVE/SCALE
- FB_BASE, 0, 15-bit base word address of the frame buffer

Ports:
- clk  in  1  system clock; also the clock of the frame-buffer read port
- rst  in  1  synchronous, active-high reset
- vram_addr  out  15  frame-buffer read address
- vram_data  in  12  frame-buffer read data {R[11:8],G[7:4],B[3:0]}
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vblank  out  1  high while vcnt >= V_ACTIVE
- frame_start  out  1  one-clk pulse at start of each frame

Behaviour:
- Reset (rst sampled high on a clk edge):
  - div_cnt, hcnt, vcnt, x_sub, y_sub, fb_x and row_base all go to 0.
  - vga_r/g/b=0, vga_hs=1, vga_vs=1, vblank=0, frame_start=0.
  - vram_addr=FB_BASE.
  - Reset mid-frame restarts the raster at pixel (0,0). No partial sync pulse may persist past the reset cycle.
- Pixel enable (pe):
  - div_cnt counts 0..CLK_DIV-1 and wraps; pe=1 when div_cnt==CLK_DIV-1.
  - All timing and address state advances only on pe.
- Timing counters:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - hcnt wraps at H_TOTAL-1. vcnt increments when hcnt wraps, and itself wraps at V_TOTAL-1.
  - active = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
- Address generation (no multiplier):
  - vram_addr = FB_BASE + row_base + fb_x, combinational from registered counters. It is stable for the whole pixel period.
  - On pe while active:
    - x_sub increments.
    - At x_sub==SCALE-1: x_sub=0 and fb_x increments.
  - On pe at hcnt==H_TOTAL-1 (line end): fb_x=0 and x_sub=0.
    - If vcnt<V_ACTIVE, y_sub increments.
    - At y_sub==SCALE-1: y_sub=0 and row_base += FB_W.
  - On pe at frame wrap (hcnt==H_TOTAL-1 && vcnt==V_TOTAL-1): row_base=0 and y_sub=0.
  - During blanking, vram_addr holds its value.
  - The last address read in a frame is FB_BASE+(V_ACTIVE/SCALE-1)*FB_W+FB_W-1 (19199 by default). Address arithmetic is 15-bit and wraps modulo 2^15.
- Output stage, registered on pe (one pixel period of latency, all outputs aligned):
  - vga_r/g/b = vram_data fields if active for the pixel being retired, else 0.
  - vga_hs = !(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)).
  - vga_vs = !(vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)).
  - vblank = (vcnt>=V_ACTIVE).
  - vram_data is sampled on the pe edge. This is RD_LAT..CLK_DIV-1 cycles after the address changed, so the data is always valid.
- frame_start is high for exactly one clk, on the pe cycle where hcnt and vcnt both wrap to 0. It is 0 otherwise.
- The block never writes memory.

Decomposition:
- Package vga_pkg:
  - Default 640x480 timing constants and H_TOTAL/V_TOTAL.
  - 12-bit pixel field positions.
  - PIX_W=12 and VRAM_AW=15.
- Sub-module vga_timing_gen:
  - Contains div_cnt, hcnt, vcnt, pe, active, raw sync and the line_end/frame_end strobes.
  - The top level holds the address generator and the output register stage.

Test Plan:
1. Reset release -> first pe: vram_addr=0. Pixel hcnt=4 (16 clk later) presents vram_addr=1. Pixel hcnt=639 presents 159. Line vcnt=4 starts at 160.
2. Timing: measure HS low = 96*4 = 384 clk, line period = 3200 clk, VS low = 2*3200 = 6400 clk, frame period = 1,680,000 clk. frame_start pulses once per frame, 1 clk wide.
3. Memory model returning data = address[11:0] with RD_LAT=1 -> output at pixel (8,0) is 0x002 one pixel period later. RGB is 0 throughout blanking.
4. RD_LAT=3, CLK_DIV=4 -> same pixel stream as scenario 3, with no stale data at fb_x boundaries.
5. Last active pixel (639,479): vram_addr=19199. In vblank, vblank=1 and vram_addr is held. The next frame's first pixel presents vram_addr=0.
6. Assert rst for 1 clk at pixel (300,200) -> next cycle hs=vs=1, rgb=0, vram_addr=0. The raster resumes from (0,0) with correct timing.
